// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings,
// stream framing constants and the word-index to byte-address helper.
package imem_loader_pkg;

  localparam logic [2:0] LDR_IDLE  = 3'd0;
  localparam logic [2:0] LDR_HDR   = 3'd1;
  localparam logic [2:0] LDR_DATA  = 3'd2;
  localparam logic [2:0] LDR_DONE  = 3'd3;
  localparam logic [2:0] LDR_ERR   = 3'd4;
  // Single cycle between the last write and DONE; still counts as busy.
  localparam logic [2:0] LDR_DRAIN = 3'd5;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [31:0] word_to_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Big-endian byte-to-word packer. word presents the value that the current
// byte completes, so the parent can act on the same edge that accepts it.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  logic [31:0] w_word;

  assign w_word        = {r_word[23:0], byte_in};
  assign word          = w_word;
  assign word_complete = shift_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

  // Byte counter is control state; it wraps 3 -> 0 at each word boundary.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= 2'd0;
    end else if (shift_en) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_word <= 32'd0;
    end else if (shift_en) begin
      r_word <= w_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Run-time program loader for the instruction store: reads a big-endian
// word-count header, then writes that many words at byte addresses 0,4,8,...
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = $clog2(MEM_SIZE) + 1;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_word_idx;
  logic [IDX_W-1:0] r_count;
  logic             r_we;
  logic [31:0]      r_waddr;
  logic [31:0]      r_wdata;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_start_ok;
  logic [31:0]      w_word;
  logic             w_word_done;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_last_word;
  logic             w_hdr_over;

  assign w_in_ready  = (r_state == LDR_HDR) || (r_state == LDR_DATA);
  assign w_accept    = in_valid && w_in_ready;
  assign w_start_ok  = start && ((r_state == LDR_IDLE) || (r_state == LDR_DONE) ||
                                 (r_state == LDR_ERR));
  assign w_idx_next  = r_word_idx + IDX_W'(1);
  assign w_last_word = (w_idx_next == r_count);
  // Full 32-bit compare so huge headers cannot alias into range.
  assign w_hdr_over  = (w_word > 32'(MEM_SIZE));

  imem_byte_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear         (w_start_ok),
    .shift_en      (w_accept),
    .byte_in       (in_data),
    .word          (w_word),
    .word_complete (w_word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LDR_IDLE;
      r_word_idx <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_waddr    <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        LDR_IDLE, LDR_DONE, LDR_ERR: begin
          if (start) begin
            r_state    <= LDR_HDR;
            r_word_idx <= '0;
          end
        end
        LDR_HDR: begin
          if (w_word_done) begin
            if (w_word == 32'd0) begin
              r_state <= LDR_DONE;
            end else if (w_hdr_over) begin
              r_state <= LDR_ERR;
            end else begin
              r_state <= LDR_DATA;
              r_count <= w_word[IDX_W-1:0];
            end
          end
        end
        LDR_DATA: begin
          if (w_word_done) begin
            r_we       <= 1'b1;
            r_waddr    <= word_to_addr(30'(r_word_idx));
            r_wdata    <= w_word;
            r_word_idx <= w_idx_next;
            if (w_last_word) begin
              r_state <= LDR_DRAIN;
            end
          end
        end
        LDR_DRAIN: r_state <= LDR_DONE;
        default:   r_state <= LDR_IDLE;
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign busy     = w_in_ready || (r_state == LDR_DRAIN);
  assign cpu_hold = busy;
  assign done     = (r_state == LDR_DONE);
  assign err      = (r_state == LDR_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory: it is the write side of the word-addressed instruction store that the fetch path reads. It accepts a big-endian byte stream over a valid/ready handshake, takes a 4-byte word-count header, assembles the following bytes into 32-bit words and issues one write per word at consecutive byte addresses 0, 4, 8, …. While a load is running it holds the CPU in reset, so instruction memory can be written at run time instead of only through the simulation preload file.

## Interface
Parameters:
- MEM_SIZE, 1024, instruction memory depth in 32-bit words; maximum accepted word count.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte; most significant byte of each word first.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- we  out  1  instruction-memory write strobe, one cycle per word.
- waddr  out  32  byte address of the write; always word-aligned (waddr[1:0] = 0).
- wdata  out  32  word to write.
- busy  out  1  load in progress (HDR, DATA or drain).
- cpu_hold  out  1  equal to busy; drives the core's reset.
- done  out  1  load completed; sticky until start or rst.
- err  out  1  header count exceeded MEM_SIZE; sticky until start or rst.

## Operation
- States: IDLE, HDR, DATA, DONE, ERR.
- IDLE: in_ready = 0. A start pulse moves to HDR, clears the byte counter, word index, done and err.
- HDR: in_ready = 1. Shifts 4 bytes into count[31:0], MSB first. On the edge that accepts the 4th byte:
  - count == 0 → DONE.
  - count > MEM_SIZE → ERR.
  - otherwise → DATA.
- DATA: in_ready = 1. Shifts bytes into a 32-bit packer with a 2-bit byte counter that wraps 3→0.
  - On the edge that accepts the 4th byte of a word, the packer registers we = 1, waddr = word_idx << 2 and wdata = the assembled word. word_idx then increments.
  - Bytes are accepted back-to-back with no stall across word boundaries.
  - After the final word is accepted, in_ready falls on the next cycle and the state moves to DONE.
- DONE: done = 1, in_ready = 0. A start pulse begins a new load.
- ERR: err = 1, in_ready = 0, no writes are issued. A start pulse begins a new load.
- start in HDR or DATA is ignored.
- in_data is ignored when in_valid = 0.
- word_idx width is $clog2(MEM_SIZE)+1. The comparison against MEM_SIZE uses the full 32-bit count.
- rst mid-load: the block returns to IDLE immediately. Words already written are not erased.

## Timing
- Reset values: in_ready = 0, we = 0, waddr = 0, wdata = 0, busy = 0, cpu_hold = 0, done = 0, err = 0.
- start at edge t → state HDR and in_ready = 1 from cycle t+1.
- we is a registered 1-cycle pulse, asserted in the cycle after the edge that accepted the word's 4th byte. waddr and wdata are valid in that same cycle.
- For the last word: done rises in the cycle after its we pulse, and busy/cpu_hold fall in that same cycle.
- count == 0: done rises in the cycle after the 4th header byte is accepted, with no we pulse.
- Overflow count: err rises in the cycle after the 4th header byte is accepted.
- Maximum throughput is 1 byte per cycle. Minimum load time is 4 + 4·N accepted bytes plus 1 drain cycle.

## Structure
- Add to src/defines.vh: state encodings LDR_IDLE, LDR_HDR, LDR_DATA, LDR_DONE, LDR_ERR (3-bit) and the byte-per-word constant 4.
- One sub-module, imem_byte_packer, used for both the header and the data words:
  - Inputs: clk, rst, clear, shift_en, byte_in.
  - Outputs: word, word_complete.
- Top-level FSM, counters and write registers live in imem_loader.

## Test plan
- Reset: hold rst for 2 cycles with in_valid = 1 → all outputs 0 and no we pulse.
- Basic load: start, then back-to-back bytes 00 00 00 02 12 34 56 78 9A BC DE F0 → we at waddr 0x0 with wdata 0x12345678, then we at waddr 0x4 with wdata 0x9ABCDEF0; done = 1 and busy = 0 one cycle after the second we.
- Stalled stream: same bytes as the basic load, with in_valid toggling every other cycle → identical writes and values; in_data changes while in_valid = 0 have no effect.
- Zero and overflow headers:
  - Header 00 00 00 00 → done = 1 with no we.
  - Header 00 00 04 01 (1025, with MEM_SIZE = 1024) → err = 1, no we, in_ready = 0.
- Reset mid-load: assert rst after 5 data bytes → outputs return to reset values next cycle; a fresh start with count 1 and bytes AA BB CC DD → single we at waddr 0x0 with wdata 0xAABBCCDD.
- Ignored start: pulse start during DATA → no restart; waddr sequence continues 0x0, 0x4, … and done rises once.
